pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). It drives the write enables and bubble-insert (flush) controls of the PC and the four stage registers, and selects the PC source.
- Resolves load-use hazards, control redirects resolved in MEM, and multi-cycle data-memory waits.
- Sits beside the datapath; consumes decode/control fields already carried in the stage registers.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3; 3 = no forwarding path)
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_err is raised (8-bit counter, 1..255)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-high
fd_ins  in  32  instruction in FD register; rs=[25:21], rt=[20:16]
fd_uses_rt  in  1  ID instruction reads rt as a source
de_dst_reg  in  5  destination register of instruction in EX
de_mem_read  in  1  instruction in EX is a load
em_dec_branch  in  1  conditional branch in MEM
em_alu_result_zero  in  1  branch condition result in MEM
em_dec_jmp  in  1  jump in MEM
em_dec_alu_result_to_pc  in  1  register-indirect jump in MEM
em_mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_wren  out  1  PC write enable
pc_sel_redirect  out  1  1: PC loads redirect target (branch_pc/alu_result); 0: sequential
fd_wren, de_wren, em_wren, mw_wren  out  1 each  stage register write enables
fd_flush, de_flush, em_flush, mw_flush  out  1 each  load bubble (all-zero) into the stage next edge; overrides wren
mem_timeout_err  out  1  sticky: a memory access exceeded MEM_TIMEOUT

Behaviour:
- Outputs are combinational from state plus inputs; state is registered.
- While reset=1: all wren=0, all flush=1, pc_sel_redirect=0, mem_timeout_err=0.
- First edge after reset deasserts: state=RUN.
- States:
  - RUN: normal issue.
  - LOAD_STALL: counter cnt counts down the remaining bubbles.
  - MEM_WAIT: memory access outstanding.
  - REDIRECT: one cycle, squashes the wrong-path instructions.
- redirect = em_dec_jmp | em_dec_alu_result_to_pc | (em_dec_branch & em_alu_result_zero).
- load_use = de_mem_read & de_dst_reg!=0 & (de_dst_reg==rs | (fd_uses_rt & de_dst_reg==rt)).
- Event priority when several occur in one cycle: mem_wait (em_mem_req & !mem_ready) > redirect > load_use.
- mem_wait, any state:
  - pc/fd/de/em wren=0, mw_flush=1.
  - Go to MEM_WAIT; counter increments.
  - Stays until mem_ready=1. On that cycle all wren=1 and mw_flush=0, then return to RUN.
- redirect in RUN:
  - pc_wren=1, pc_sel_redirect=1.
  - fd_flush=de_flush=em_flush=1; MW loads normally.
  - Next state RUN. A pending LOAD_STALL is cancelled because the load_use instruction was squashed.
- load_use in RUN:
  - pc_wren=fd_wren=0, de_flush=1, em/mw wren=1.
  - If LOAD_STALL_CYCLES>1: state=LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
  - The same outputs hold until cnt reaches 0, then RUN. load_use is not re-evaluated in LOAD_STALL.
- RUN with no event: all wren=1, all flush=0, pc_sel_redirect=0.
- Timeout: when the MEM_WAIT counter reaches MEM_TIMEOUT, set mem_timeout_err (sticky until reset) and keep waiting. The counter saturates; it clears on leaving MEM_WAIT.
- Reset mid-stall or mid-wait: state returns to RUN, counters clear, mem_timeout_err clears.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stall_count[31:0], flush_count[31:0] and mem_wait_count[31:0], zero on reset, wrapping at 2^32.
  - stall_count: +1 per cycle pc_wren=0 due to load_use/LOAD_STALL.
  - flush_count: +1 per redirect.
  - mem_wait_count: +1 per MEM_WAIT cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset 3 cycles, then idle inputs -> during reset wren=0 and flush=1; first cycle after: all wren=1, all flush=0, mem_timeout_err=0.
- de_mem_read=1, de_dst_reg=5, fd_ins rs=5, LOAD_STALL_CYCLES=1 -> one cycle with pc_wren=fd_wren=0 and de_flush=1, next cycle RUN; repeat with rt=5 and fd_uses_rt=0 -> no stall; de_dst_reg=0 -> no stall.
- em_dec_branch=1, em_alu_result_zero=1 together with load_use -> pc_sel_redirect=1, fd/de/em_flush=1, no stall cycle follows.
- em_mem_req=1, mem_ready low for 4 cycles -> 4 cycles with pc/fd/de/em wren=0 and mw_flush=1; cycle 5 (mem_ready=1) all wren=1; with redirect held high in the same cycles, redirect only takes effect after the wait ends.
- MEM_TIMEOUT=8, mem_ready held low 12 cycles -> mem_timeout_err rises after the 8th wait cycle, stays high after completion, clears on reset.
- HAZARD_STATS_EN defined; 2 load-use stalls, 1 redirect, 3 wait cycles -> stall_count=2, flush_count=1, mem_wait_count=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and PC-select sequencer for the 5-stage pipeline.
// It resolves load-use hazards, redirects resolved in MEM and data-memory waits.
// Build option: define HAZARD_STATS_EN to add the stall/flush/mem-wait event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fd_ins,
    input  logic        fd_uses_rt,
    input  logic [4:0]  de_dst_reg,
    input  logic        de_mem_read,
    input  logic        em_dec_branch,
    input  logic        em_alu_result_zero,
    input  logic        em_dec_jmp,
    input  logic        em_dec_alu_result_to_pc,
    input  logic        em_mem_req,
    input  logic        mem_ready,
    output logic        pc_wren,
    output logic        pc_sel_redirect,
    output logic        fd_wren,
    output logic        de_wren,
    output logic        em_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        mw_flush,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] mem_wait_count,
`endif
    output logic        mem_timeout_err
);

    typedef enum logic [1:0] {StRun, StLoadStall, StMemWait, StRedirect} state_e;

    localparam logic [1:0] StallInit  = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic [4:0] rs, rt;
    logic       redirect, load_use, mem_wait;
    logic       stall_cyc, redirect_taken;
    logic       unused_ins;

    assign rs         = fd_ins[25:21];
    assign rt         = fd_ins[20:16];
    assign unused_ins = ^{fd_ins[31:26], fd_ins[15:0]};

    assign redirect = em_dec_jmp | em_dec_alu_result_to_pc | (em_dec_branch & em_alu_result_zero);
    assign load_use = de_mem_read && (de_dst_reg != 5'd0) &&
                      ((de_dst_reg == rs) || (fd_uses_rt && (de_dst_reg == rt)));
    assign mem_wait = em_mem_req && !mem_ready;

    // Next-state and stage-control decode; priority is mem_wait > redirect > load_use.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        wait_cnt_d      = 8'd0;
        err_d           = err_q;
        pc_wren         = 1'b1;
        pc_sel_redirect = 1'b0;
        fd_wren         = 1'b1;
        de_wren         = 1'b1;
        em_wren         = 1'b1;
        mw_wren         = 1'b1;
        fd_flush        = 1'b0;
        de_flush        = 1'b0;
        em_flush        = 1'b0;
        mw_flush        = 1'b0;
        stall_cyc       = 1'b0;
        redirect_taken  = 1'b0;

        if (reset) begin
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_wren  = 1'b0;
            em_wren  = 1'b0;
            mw_wren  = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
            state_d  = StRun;
            cnt_d    = 2'd0;
            err_d    = 1'b0;
        end else if (mem_wait) begin
            // Freeze the front of the pipe; WB receives bubbles until memory answers.
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_wren  = 1'b0;
            em_wren  = 1'b0;
            mw_flush = 1'b1;
            state_d  = StMemWait;
            cnt_d    = 2'd0;
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d == TimeoutCnt) begin
                err_d = 1'b1;
            end
        end else if (redirect) begin
            // Squash the three wrong-path instructions; this also cancels a pending stall.
            pc_sel_redirect = 1'b1;
            fd_flush        = 1'b1;
            de_flush        = 1'b1;
            em_flush        = 1'b1;
            state_d         = StRun;
            cnt_d           = 2'd0;
            redirect_taken  = 1'b1;
        end else begin
            case (state_q)
                StLoadStall: begin
                    pc_wren   = 1'b0;
                    fd_wren   = 1'b0;
                    de_flush  = 1'b1;
                    stall_cyc = 1'b1;
                    cnt_d     = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = StRun;
                    end
                end
                StMemWait: begin
                    // Access completed this cycle: everything advances.
                    state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                    if (load_use) begin
                        pc_wren   = 1'b0;
                        fd_wren   = 1'b0;
                        de_flush  = 1'b1;
                        stall_cyc = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = StLoadStall;
                            cnt_d   = StallInit;
                        end
                    end
                end
            endcase
        end
    end

    // State, bubble counter, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            cnt_q      <= 2'd0;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_timeout_err = err_q && !reset;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_cyc_q;

    // Event counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            wait_cyc_q  <= 32'd0;
        end else begin
            if (stall_cyc)      stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_taken) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (mem_wait)       wait_cyc_q  <= wait_cyc_q + 32'd1;
        end
    end

    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;
    assign mem_wait_count = wait_cyc_q;
`else
    logic unused_stats;
    assign unused_stats = stall_cyc ^ redirect_taken;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: per-cycle expectations go through a scoreboard queue.
// A second instance with LOAD_STALL_CYCLES=3 shares the inputs; only its pc_wren is observed.
// Define HAZARD_STATS_EN to also exercise the event counters.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ins = '0;
    logic        fd_uses_rt = 1'b0;
    logic [4:0]  de_dst_reg = '0;
    logic        de_mem_read = 1'b0;
    logic        em_dec_branch = 1'b0;
    logic        em_alu_result_zero = 1'b0;
    logic        em_dec_jmp = 1'b0;
    logic        em_dec_alu_result_to_pc = 1'b0;
    logic        em_mem_req = 1'b0;
    logic        mem_ready = 1'b0;

    logic pc_wren, pc_sel_redirect, fd_wren, de_wren, em_wren, mw_wren;
    logic fd_flush, de_flush, em_flush, mw_flush, mem_timeout_err;
    logic p3_pc_wren, p3_sel, p3_fd_wren, p3_de_wren, p3_em_wren, p3_mw_wren;
    logic p3_fd_flush, p3_de_flush, p3_em_flush, p3_mw_flush, p3_err;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count, mem_wait_count;
    logic [31:0] p3_stall_count, p3_flush_count, p3_mem_wait_count;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .fd_ins(fd_ins), .fd_uses_rt(fd_uses_rt),
        .de_dst_reg(de_dst_reg), .de_mem_read(de_mem_read), .em_dec_branch(em_dec_branch),
        .em_alu_result_zero(em_alu_result_zero), .em_dec_jmp(em_dec_jmp),
        .em_dec_alu_result_to_pc(em_dec_alu_result_to_pc), .em_mem_req(em_mem_req),
        .mem_ready(mem_ready), .pc_wren(pc_wren), .pc_sel_redirect(pc_sel_redirect),
        .fd_wren(fd_wren), .de_wren(de_wren), .em_wren(em_wren), .mw_wren(mw_wren),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
`ifdef HAZARD_STATS_EN
        .stall_count(stall_count), .flush_count(flush_count),
        .mem_wait_count(mem_wait_count),
`endif
        .mem_timeout_err(mem_timeout_err)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) dut3 (
        .clk(clk), .reset(reset), .fd_ins(fd_ins), .fd_uses_rt(fd_uses_rt),
        .de_dst_reg(de_dst_reg), .de_mem_read(de_mem_read), .em_dec_branch(em_dec_branch),
        .em_alu_result_zero(em_alu_result_zero), .em_dec_jmp(em_dec_jmp),
        .em_dec_alu_result_to_pc(em_dec_alu_result_to_pc), .em_mem_req(em_mem_req),
        .mem_ready(mem_ready), .pc_wren(p3_pc_wren), .pc_sel_redirect(p3_sel),
        .fd_wren(p3_fd_wren), .de_wren(p3_de_wren), .em_wren(p3_em_wren),
        .mw_wren(p3_mw_wren), .fd_flush(p3_fd_flush), .de_flush(p3_de_flush),
        .em_flush(p3_em_flush), .mw_flush(p3_mw_flush),
`ifdef HAZARD_STATS_EN
        .stall_count(p3_stall_count), .flush_count(p3_flush_count),
        .mem_wait_count(p3_mem_wait_count),
`endif
        .mem_timeout_err(p3_err)
    );

    // Observation vector: [11] dut3 pc_wren, [10] pc_wren, [9] pc_sel_redirect,
    // [8:5] fd/de/em/mw wren, [4:1] fd/de/em/mw flush, [0] mem_timeout_err.
    logic [11:0] obs;
    assign obs = {p3_pc_wren, pc_wren, pc_sel_redirect, fd_wren, de_wren, em_wren, mw_wren,
                  fd_flush, de_flush, em_flush, mw_flush, mem_timeout_err};

    localparam logic [11:0] E_RST  = 12'h01E;  // all wren 0, all flush 1
    localparam logic [11:0] E_RUN  = 12'hDE0;  // all wren 1, no flush
    localparam logic [11:0] E_RUNE = 12'hDE1;  // as E_RUN with sticky error
    localparam logic [11:0] E_P3S  = 12'h5E0;  // dut runs, dut3 still stalled
    localparam logic [11:0] E_LDU  = 12'h068;  // pc/fd hold, de bubble, em/mw load
    localparam logic [11:0] E_RED  = 12'hE3C;  // redirect, fd/de/em flushed
    localparam logic [11:0] E_MW   = 12'h002;  // pc..em hold, mw bubble
    localparam logic [11:0] E_MWE  = 12'h003;
    localparam logic [11:0] M_ALL  = 12'hFFF;
    localparam logic [11:0] M_LDU  = 12'hF7F;  // de_wren is don't-care under de_flush
    localparam logic [11:0] M_RED  = 12'hE3F;  // fd/de/em wren don't-care under flush
    localparam logic [11:0] M_MW   = 12'hFDF;  // mw_wren don't-care under mw_flush
    localparam logic [11:0] M_DONE = 12'h5E2;  // only wren bits and mw_flush

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, dst;
        logic       rd, urt, br, z, j, a2p, mq, mr;
        logic [11:0] exp, mask;
    } stim_t;

    typedef struct {
        logic [11:0] exp, mask;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic stim_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] dst, input logic rd, input logic urt,
                                 input logic br, input logic z, input logic j,
                                 input logic a2p, input logic mq, input logic mr,
                                 input logic [11:0] e, input logic [11:0] m);
        stim_t s;
        s.rst = rst; s.rs = rs; s.rt = rt; s.dst = dst; s.rd = rd; s.urt = urt;
        s.br = br; s.z = z; s.j = j; s.a2p = a2p; s.mq = mq; s.mr = mr;
        s.exp = e; s.mask = m;
        return s;
    endfunction

    function automatic stim_t idle(input logic [11:0] e, input logic [11:0] m);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, m);
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show for it.
    task automatic apply(input stim_t s);
        sb_t e;
        reset                   = s.rst;
        fd_ins                  = {6'd0, s.rs, s.rt, 16'h1234};
        fd_uses_rt              = s.urt;
        de_dst_reg              = s.dst;
        de_mem_read             = s.rd;
        em_dec_branch           = s.br;
        em_alu_result_zero      = s.z;
        em_dec_jmp              = s.j;
        em_dec_alu_result_to_pc = s.a2p;
        em_mem_req              = s.mq;
        mem_ready               = s.mr;
        e.exp  = s.exp;
        e.mask = s.mask;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t seq[$];
        sb_t   e;
        for (int k = 0; k < 3; k++) seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                                      E_RST, M_ALL));
        seq.push_back(idle(E_RUN, M_ALL));
        foreach (seq[i]) begin
            @(posedge clk); #1; apply(seq[i]);
            #5; e = sb.pop_front(); n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask))
                $display("FAIL reset[%0d]: got %h, expected %h (mask %h)",
                         i, obs & e.mask, e.exp, e.mask);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        sb_t   e;
        seq.push_back(mk(0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, E_LDU, M_LDU)); // rs hit
        seq.push_back(idle(E_P3S, M_ALL));
        seq.push_back(idle(E_P3S, M_ALL));
        seq.push_back(idle(E_RUN, M_ALL));
        seq.push_back(mk(0, 3, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL)); // rt, not used
        seq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL)); // r0 load
        seq.push_back(mk(0, 3, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, E_LDU, M_LDU)); // rt hit
        seq.push_back(idle(E_P3S, M_ALL));
        seq.push_back(idle(E_P3S, M_ALL));
        seq.push_back(idle(E_RUN, M_ALL));
        foreach (seq[i]) begin
            @(posedge clk); #1; apply(seq[i]);
            #5; e = sb.pop_front(); n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask))
                $display("FAIL load_use[%0d]: got %h, expected %h (mask %h)",
                         i, obs & e.mask, e.exp, e.mask);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        stim_t seq[$];
        sb_t   e;
        seq.push_back(mk(0, 5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, E_RED, M_RED)); // with load_use
        seq.push_back(idle(E_RUN, M_ALL));                                   // no stall follows
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN, M_ALL)); // not taken
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_RED, M_RED)); // jump
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RED, M_RED)); // indirect
        seq.push_back(idle(E_RUN, M_ALL));
        foreach (seq[i]) begin
            @(posedge clk); #1; apply(seq[i]);
            #5; e = sb.pop_front(); n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask))
                $display("FAIL redirect[%0d]: got %h, expected %h (mask %h)",
                         i, obs & e.mask, e.exp, e.mask);
            else n_pass++;
        end
    endtask

    task automatic test_mem_wait();
        stim_t seq[$];
        sb_t   e;
        for (int k = 0; k < 4; k++)
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MW, M_MW));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, M_ALL));
        seq.push_back(idle(E_RUN, M_ALL));
        for (int k = 0; k < 4; k++)  // redirect held during the wait is ignored
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_MW, M_MW));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_P3S, M_DONE));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_RED, M_RED));
        seq.push_back(idle(E_RUN, M_ALL));
        foreach (seq[i]) begin
            @(posedge clk); #1; apply(seq[i]);
            #5; e = sb.pop_front(); n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask))
                $display("FAIL mem_wait[%0d]: got %h, expected %h (mask %h)",
                         i, obs & e.mask, e.exp, e.mask);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        stim_t seq[$];
        sb_t   e;
        for (int k = 1; k <= 12; k++)  // error visible from the 9th wait cycle on
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                             (k <= 8) ? E_MW : E_MWE, M_MW));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUNE, M_ALL));
        seq.push_back(idle(E_RUNE, M_ALL));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, M_ALL));
        seq.push_back(idle(E_RUN, M_ALL));
        foreach (seq[i]) begin
            @(posedge clk); #1; apply(seq[i]);
            #5; e = sb.pop_front(); n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask))
                $display("FAIL timeout[%0d]: got %h, expected %h (mask %h)",
                         i, obs & e.mask, e.exp, e.mask);
            else n_pass++;
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        stim_t seq[$];
        sb_t   e;
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 12'h7FF));
        seq.push_back(mk(0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, E_LDU, 12'h77F));
        seq.push_back(idle(E_RUN, 12'h7FF));
        seq.push_back(mk(0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, E_LDU, 12'h77F));
        seq.push_back(idle(E_RUN, 12'h7FF));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, E_RED, 12'h63F));
        seq.push_back(idle(E_RUN, 12'h7FF));
        for (int k = 0; k < 3; k++)
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MW, 12'h5DF));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 12'h7FF));
        seq.push_back(idle(E_RUN, 12'h7FF));
        foreach (seq[i]) begin
            @(posedge clk); #1; apply(seq[i]);
            #5; e = sb.pop_front(); n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask))
                $display("FAIL stats_seq[%0d]: got %h, expected %h (mask %h)",
                         i, obs & e.mask, e.exp, e.mask);
            else n_pass++;
        end
        n_checks++;
        if (stall_count !== 32'd2)
            $display("FAIL stall_count: got %0d, expected 2", stall_count);
        else n_pass++;
        n_checks++;
        if (flush_count !== 32'd1)
            $display("FAIL flush_count: got %0d, expected 1", flush_count);
        else n_pass++;
        n_checks++;
        if (mem_wait_count !== 32'd3)
            $display("FAIL mem_wait_count: got %0d, expected 3", mem_wait_count);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
